// File: rtl/proc_core_pkg.sv
// Shared ISA constants and field layouts for the proc_core game-logic CPU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package proc_core_pkg;

  // Primary opcodes, instruction bits [31:27]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type function codes, instruction bits [6:2]
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  // Architectural register roles
  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  // Status codes written to the status register on signed overflow
  localparam logic [31:0] STATUS_ADD  = 32'd1;
  localparam logic [31:0] STATUS_ADDI = 32'd2;
  localparam logic [31:0] STATUS_SUB  = 32'd3;

  // R-type view of an instruction word; I/JI fields overlay the same bits
  typedef struct packed {
    logic [4:0] op;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] shamt;
    logic [4:0] aluop;
    logic [1:0] pad;
  } instr_t;

  // 17-bit immediate to 32-bit two's complement
  function automatic logic [31:0] sext17(input logic [16:0] v);
    return {{15{v[16]}}, v};
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Integer ALU: add/sub/and/or/sll/sra plus compare flags and signed overflow.
// Latency: purely combinational.
// Backpressure: none; outputs follow operands every cycle.
module proc_alu
  import proc_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  aluop,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        ovf,
  output logic        ne,
  output logic        lt
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Flags are independent of the selected operation so branches can reuse them
  assign ne = (a != b);
  assign lt = ($signed(a) < $signed(b));

  // Select result; overflow only reported for add and sub
  always_comb begin
    result = sum;
    ovf    = 1'b0;
    case (aluop)
      ALU_ADD: begin
        result = sum;
        ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << shamt;
      ALU_SRA: result = $signed(a) >>> shamt;
      default: result = sum;
    endcase
  end

endmodule

// File: rtl/proc_core.sv
// Single-cycle 32-bit core: decode, ALU, writeback select and PC sequencing.
// Latency: one instruction per cycle; only the PC is state.
// Backpressure: none; memories and regfile are assumed to answer within the cycle.
module proc_core
  import proc_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DADDR_W  = 17
) (
  input  logic               clock,
  input  logic               reset,
  output logic [11:0]        address_imem,
  input  logic [31:0]        q_imem,
  output logic [DADDR_W-1:0] address_dmem,
  output logic [31:0]        data,
  output logic               wren,
  input  logic [31:0]        q_dmem,
  output logic               ctrl_writeEnable,
  output logic [4:0]         ctrl_writeReg,
  output logic [4:0]         ctrl_readRegA,
  output logic [4:0]         ctrl_readRegB,
  output logic [31:0]        data_writeReg,
  input  logic [31:0]        data_readRegA,
  input  logic [31:0]        data_readRegB
);

  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic [31:0] pc_next;
  instr_t      ins;
  logic [31:0] imm;
  logic [31:0] target;

  logic is_r, r_valid, is_addi, is_sw, is_lw, is_j, is_jal, is_jr;
  logic is_bne, is_blt, is_bex, is_setx, use_imm;

  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_ovf, alu_ne, alu_lt;

  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  assign ins      = q_imem;
  assign imm      = sext17(q_imem[16:0]);
  assign target   = {5'd0, q_imem[26:0]};
  assign pc_plus1 = pc + 32'd1;

  assign is_r    = (ins.op == OP_RTYPE);
  assign r_valid = is_r && (ins.aluop inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA});
  assign is_addi = (ins.op == OP_ADDI);
  assign is_sw   = (ins.op == OP_SW);
  assign is_lw   = (ins.op == OP_LW);
  assign is_j    = (ins.op == OP_J);
  assign is_jal  = (ins.op == OP_JAL);
  assign is_jr   = (ins.op == OP_JR);
  assign is_bne  = (ins.op == OP_BNE);
  assign is_blt  = (ins.op == OP_BLT);
  assign is_bex  = (ins.op == OP_BEX);
  assign is_setx = (ins.op == OP_SETX);
  assign use_imm = is_addi || is_sw || is_lw;

  // bex tests the status register; stores and branches read $rd on port B
  assign ctrl_readRegA = is_bex ? REG_STATUS : ins.rs;
  assign ctrl_readRegB = is_r ? ins.rt : ins.rd;

  // For branches A=$rs and B=$rd, so "$rd < $rs" is "not A<B and A!=B"
  assign alu_b  = use_imm ? imm : data_readRegB;
  assign alu_op = is_r ? ins.aluop : ALU_ADD;

  proc_alu u_alu (
    .a      (data_readRegA),
    .b      (alu_b),
    .aluop  (alu_op),
    .shamt  (ins.shamt),
    .result (alu_result),
    .ovf    (alu_ovf),
    .ne     (alu_ne),
    .lt     (alu_lt)
  );

  assign address_imem = pc[11:0];
  assign address_dmem = alu_result[DADDR_W-1:0];
  assign data         = data_readRegB;
  assign wren         = is_sw && !reset;

  // Writeback select; overflow redirects the write to the status register
  always_comb begin
    wb_en   = 1'b0;
    wb_reg  = ins.rd;
    wb_data = alu_result;
    if (r_valid) begin
      wb_en = 1'b1;
      if (alu_ovf) begin
        wb_reg  = REG_STATUS;
        wb_data = (ins.aluop == ALU_SUB) ? STATUS_SUB : STATUS_ADD;
      end
    end else if (is_addi) begin
      wb_en = 1'b1;
      if (alu_ovf) begin
        wb_reg  = REG_STATUS;
        wb_data = STATUS_ADDI;
      end
    end else if (is_lw) begin
      wb_en   = 1'b1;
      wb_data = q_dmem;
    end else if (is_jal) begin
      wb_en   = 1'b1;
      wb_reg  = REG_LINK;
      wb_data = pc_plus1;
    end else if (is_setx) begin
      wb_en   = 1'b1;
      wb_reg  = REG_STATUS;
      wb_data = target;
    end
  end

  assign ctrl_writeEnable = wb_en && (wb_reg != REG_ZERO) && !reset;
  assign ctrl_writeReg    = wb_reg;
  assign data_writeReg    = wb_data;

  // Next-PC select: jumps, taken branches, otherwise fall through
  always_comb begin
    pc_next = pc_plus1;
    if (is_j || is_jal) begin
      pc_next = target;
    end else if (is_jr) begin
      pc_next = data_readRegB;
    end else if (is_bne && alu_ne) begin
      pc_next = pc_plus1 + imm;
    end else if (is_blt && alu_ne && !alu_lt) begin
      pc_next = pc_plus1 + imm;
    end else if (is_bex && (data_readRegA != 32'd0)) begin
      pc_next = target;
    end
  end

  // PC register; reset takes effect immediately, even mid-cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_proc_core.sv
// Bench for proc_core: ISA-level model plus environment memories and regfile.
// Latency: checks every falling edge against the model's view of the current instruction.
// Backpressure: n/a.
module tb_proc_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic [16:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;

  always #5 clock = ~clock;

  proc_core #(.RESET_PC(32'd0), .DADDR_W(17)) dut (
    .clock            (clock),
    .reset            (reset),
    .address_imem     (address_imem),
    .q_imem           (q_imem),
    .address_dmem     (address_dmem),
    .data             (data),
    .wren             (wren),
    .q_dmem           (q_dmem),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  // Environment: instruction ROM, register file and data memory
  logic [31:0] imem  [0:4095];
  logic [31:0] rf    [0:31]   = '{default: 32'd0};
  logic [31:0] dmem  [0:8191] = '{default: 32'd0};

  assign q_imem        = imem[address_imem];
  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];
  assign q_dmem        = dmem[address_dmem[12:0]];

  // Environment writes at the end of each instruction; word 4200 is an I/O reading 260
  always @(posedge clock) begin
    if (reset) dmem[4200] <= 32'd260;
    if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
    if (wren) dmem[address_dmem[12:0]] <= data;
  end

  // ISA model state
  logic [31:0] mpc = 32'd0;
  logic [31:0] mrf   [0:31]   = '{default: 32'd0};
  logic [31:0] mdmem [0:8191] = '{default: 32'd0};

  typedef struct packed {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        wren;
    logic        is_lw;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] npc;
  } exp_t;

  // Architectural effect of the instruction at the model PC
  function automatic exp_t model_eval();
    exp_t        e;
    logic [31:0] ins, vs, vt, vd, imm, t, pc1;
    logic [4:0]  op, rd, rs, rt, sh, fn;
    logic [4:0]  dst;
    logic [31:0] val;
    logic        wr;
    longint      r;
    ins = imem[mpc[11:0]];
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    sh = ins[11:7];  fn = ins[6:2];
    vs = mrf[rs]; vt = mrf[rt]; vd = mrf[rd];
    imm = {{15{ins[16]}}, ins[16:0]};
    t   = {5'd0, ins[26:0]};
    pc1 = mpc + 32'd1;
    e = '0;
    e.npc = pc1;
    wr = 1'b0; dst = rd; val = 32'd0;
    case (op)
      5'd0: begin
        wr = 1'b1;
        case (fn)
          5'd0: begin
            r = longint'($signed(vs)) + longint'($signed(vt));
            if (r != longint'($signed(r[31:0]))) begin dst = 5'd30; val = 32'd1; end
            else val = r[31:0];
          end
          5'd1: begin
            r = longint'($signed(vs)) - longint'($signed(vt));
            if (r != longint'($signed(r[31:0]))) begin dst = 5'd30; val = 32'd3; end
            else val = r[31:0];
          end
          5'd2: val = vs & vt;
          5'd3: val = vs | vt;
          5'd4: val = vs << sh;
          5'd5: val = $signed(vs) >>> sh;
          default: wr = 1'b0;
        endcase
      end
      5'd5: begin
        wr = 1'b1;
        r = longint'($signed(vs)) + longint'($signed(imm));
        if (r != longint'($signed(r[31:0]))) begin dst = 5'd30; val = 32'd2; end
        else val = r[31:0];
      end
      5'd7: begin e.wren = 1'b1; e.addr = vs + imm; e.sdata = vd; end
      5'd8: begin
        e.is_lw = 1'b1; e.addr = vs + imm;
        wr = 1'b1; val = mdmem[e.addr[12:0]];
      end
      5'd1: e.npc = t;
      5'd3: begin wr = 1'b1; dst = 5'd31; val = pc1; e.npc = t; end
      5'd4: e.npc = vd;
      5'd2: if (vd != vs) e.npc = pc1 + imm;
      5'd6: if ($signed(vd) < $signed(vs)) e.npc = pc1 + imm;
      5'd22: if (mrf[30] != 32'd0) e.npc = t;
      5'd21: begin wr = 1'b1; dst = 5'd30; val = t; end
      default: ;
    endcase
    e.we = wr && (dst != 5'd0);
    e.wr = dst;
    e.wd = val;
    return e;
  endfunction

  // Model advances one instruction per rising edge
  always @(posedge clock or posedge reset) begin
    exp_t e;
    if (reset) begin
      mpc <= 32'd0;
      mdmem[4200] <= 32'd260;
    end else begin
      e = model_eval();
      if (e.we) mrf[e.wr] <= e.wd;
      if (e.wren) mdmem[e.addr[12:0]] <= e.sdata;
      mpc <= e.npc;
    end
  end

  int checks = 0;
  int passes = 0;
  int trace[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Compare DUT outputs with the model away from the rising edge
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      check("reset_pc", {20'd0, address_imem}, 32'd0);
      check("reset_wren", {31'd0, wren}, 32'd0);
      check("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
    end else begin
      e = model_eval();
      trace.push_back(int'(address_imem));
      check("pc", {20'd0, address_imem}, {20'd0, mpc[11:0]});
      check("we", {31'd0, ctrl_writeEnable}, {31'd0, e.we});
      if (e.we) begin
        check("wreg", {27'd0, ctrl_writeReg}, {27'd0, e.wr});
        check("wdata", data_writeReg, e.wd);
      end
      check("wren", {31'd0, wren}, {31'd0, e.wren});
      if (e.wren) begin
        check("st_addr", {15'd0, address_dmem}, {15'd0, e.addr[16:0]});
        check("st_data", data, e.sdata);
      end
      if (e.is_lw) check("ld_addr", {15'd0, address_dmem}, {15'd0, e.addr[16:0]});
    end
  end

  function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt, input int sh);
    return {5'd0, rd[4:0], rs[4:0], rt[4:0], sh[4:0], fn[4:0], 2'b00};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
    return {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input int t);
    return {op[4:0], t[26:0]};
  endfunction

  int exp_trace[38] = '{0, 1, 2, 3, 4, 5, 20, 6, 7, 8, 9, 10, 14, 15, 16, 17, 18, 19,
                        21, 22, 23, 24, 25, 10, 11, 30, 31, 34, 35, 36, 40, 41, 42,
                        43, 44, 45, 46, 46};
  int exp_regs[14][2] = '{'{1, 10}, '{2, 10}, '{3, 260}, '{4, 32'h8000_0000}, '{5, 0},
                          '{9, 32'hFFFF_FFFF}, '{11, 32'h7FFF_FFFF}, '{12, 0}, '{15, 0},
                          '{16, 15}, '{17, 32'hF800_0000}, '{18, 2}, '{30, 0}, '{31, 6}};

  initial begin
    logic [31:0] tv;
    for (int i = 0; i < 4096; i++) imem[i] = 32'd0;
    imem[3]  = enc_i(5, 1, 0, 5);          // addi r1,r0,5
    imem[4]  = enc_r(0, 2, 1, 1, 0);       // add  r2,r1,r1
    imem[5]  = enc_j(3, 20);               // jal  20
    imem[20] = enc_i(4, 31, 0, 0);         // jr   r31
    imem[6]  = enc_i(5, 6, 0, 1);          // addi r6,r0,1
    imem[7]  = enc_r(4, 4, 6, 0, 31);      // sll  r4,r6,31
    imem[8]  = enc_i(5, 9, 0, -1);         // addi r9,r0,-1
    imem[9]  = enc_r(1, 11, 9, 4, 0);      // sub  r11,r9,r4 -> 0x7fffffff
    imem[10] = enc_i(2, 1, 2, 3);          // bne  r1,r2,3
    imem[11] = enc_j(1, 30);               // j    30
    imem[14] = enc_r(0, 12, 11, 6, 0);     // add overflow -> r30=1
    imem[15] = enc_r(1, 13, 4, 6, 0);      // sub overflow -> r30=3
    imem[16] = enc_i(5, 14, 11, 1);        // addi overflow -> r30=2
    imem[17] = enc_r(2, 15, 2, 1, 0);      // and
    imem[18] = enc_r(3, 16, 2, 1, 0);      // or
    imem[19] = enc_j(1, 21);               // j    21
    imem[21] = enc_r(5, 17, 4, 0, 4);      // sra  r17,r4,4
    imem[22] = enc_i(7, 1, 0, 4100);       // sw   r1,4100(r0)
    imem[23] = enc_i(8, 3, 0, 4200);       // lw   r3,4200(r0)
    imem[24] = enc_i(5, 1, 0, 10);         // addi r1,r0,10
    imem[25] = enc_j(1, 10);               // j    10 (bne now falls through)
    imem[30] = enc_i(5, 18, 0, 2);         // addi r18,r0,2
    imem[31] = enc_i(6, 9, 18, 2);         // blt  -1 < 2 taken -> 34
    imem[34] = enc_i(6, 18, 9, 5);         // blt  2 < -1 not taken
    imem[35] = enc_j(21, 7);               // setx 7
    imem[36] = enc_j(22, 40);              // bex  40 taken
    imem[40] = enc_j(21, 0);               // setx 0
    imem[41] = enc_j(22, 50);              // bex  50 not taken
    imem[42] = 32'hF800_0000;              // unknown opcode
    imem[43] = enc_r(6, 5, 1, 1, 0);       // unknown aluop, no write
    imem[44] = enc_r(0, 0, 1, 1, 0);       // add to r0, no write
    imem[46] = enc_j(1, 46);               // park

    repeat (3) @(posedge clock);
    #1;
    check("lit_reset_pc", {20'd0, address_imem}, 32'd0);
    check("lit_reset_wren", {31'd0, wren}, 32'd0);
    check("lit_reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
    reset = 1'b0;

    repeat (60) @(posedge clock);
    #1;
    for (int i = 0; i < 38; i++) begin
      tv = (i < trace.size()) ? trace[i] : 32'hFFFF_FFFF;
      check($sformatf("trace%0d", i), tv, exp_trace[i]);
    end
    for (int i = 0; i < 14; i++) begin
      check($sformatf("model_r%0d", exp_regs[i][0]), mrf[exp_regs[i][0]], exp_regs[i][1]);
      check($sformatf("rf_r%0d", exp_regs[i][0]), rf[exp_regs[i][0]], exp_regs[i][1]);
    end
    check("mem_4100", dmem[4100], 32'd5);

    // Asynchronous reset in the middle of a cycle
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", {20'd0, address_imem}, 32'd0);
    check("async_rst_wren", {31'd0, wren}, 32'd0);
    check("async_rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    trace.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("restart_len", trace.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      tv = (i < trace.size()) ? trace[i] : 32'hFFFF_FFFF;
      check($sformatf("restart%0d", i), tv, i);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/proc_core.md
Name: proc_core

Overview:
- Single-cycle 32-bit RISC core (ECE350-style ISA) driving the game logic of the Pacman system.
- Fetches from an external instruction memory, talks to an external data memory / memory-mapped I/O bus, and uses an external 32x32 register file.
- The surrounding wrapper clocks memories and regfile on the inverted clock; the core updates its PC on the rising edge.

Parameters:
- RESET_PC, 0, PC value loaded on reset.
- DADDR_W, 17, data address width; addresses ≥4096 are I/O decoded by the wrapper.

Ports:
- clock  in  1  master clock; PC updates on rising edge.
- reset  in  1  asynchronous, active-high.
- address_imem  out  12  PC[11:0].
- q_imem  in  32  instruction word for the current PC.
- address_dmem  out  17  ALU result[16:0] for lw/sw.
- data  out  32  store data (value of $rd).
- wren  out  1  store strobe, high only during sw.
- q_dmem  in  32  load data (memory or I/O word).
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  destination register.
- ctrl_readRegA, ctrl_readRegB  out  5  each  source register selects.
- data_writeReg  out  32  writeback value.
- data_readRegA, data_readRegB  in  32  each  register operands.

Behaviour:
- Instruction formats:
  - R: op[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2].
  - I: op, rd, rs, imm[16:0], sign-extended to 32 bits.
  - JI: op, T[26:0], zero-extended.
- Opcodes:
  - 00000 R-type, with aluop add 00000, sub 00001, and 00010, or 00011, sll 00100, sra 00101.
  - 00101 addi, 00111 sw, 01000 lw.
  - 00001 j, 00011 jal, 00100 jr.
  - 00010 bne, 00110 blt.
  - 10110 bex, 10101 setx.
  - Any other opcode or aluop is a NOP.
- Operation semantics:
  - R-type: $rd = $rs op $rt.
  - addi: $rd = $rs + imm.
  - lw: $rd = mem[$rs + imm].
  - sw: mem[$rs + imm] = $rd.
  - j: PC = T.
  - jal: $r31 = PC+1, then PC = T.
  - jr: PC = $rd.
  - bne: if $rd != $rs, PC = PC+1+imm.
  - blt: if $rd < $rs (signed), PC = PC+1+imm.
  - bex: if $r30 != 0, PC = T.
  - setx: $r30 = T.
- Otherwise PC = PC+1, 32-bit wrap-around.
- Register port mapping:
  - readRegA = rs; readRegA = 30 for bex.
  - readRegB = rt for R-type; readRegB = rd for sw, bne, blt, jr.
- Overflow (signed, 32-bit): add, addi and sub write $r30 instead of $rd, with value 1 (add), 2 (addi) or 3 (sub).
- Shifts use shamt; sra is arithmetic.
- ctrl_writeEnable asserts for R-type, addi, lw, jal and setx, and never when the target register is 0.
- All outputs are combinational from PC, q_imem and the register/memory inputs; the only state is the PC.
- Latency: one instruction per cycle. Load data in q_dmem is valid by the rising edge ending the cycle; writeback occurs on the regfile's edge.
- wren is 0 for all non-sw instructions. data and address_dmem are don't-care when wren = 0 and the instruction is not lw.
- Reset:
  - Asserting reset forces PC = RESET_PC immediately, including mid-instruction.
  - While reset is high, wren = 0 and ctrl_writeEnable = 0.
  - The first fetch after deassertion is address 0.

Decomposition:
- Shared package: opcode constants, aluop constants, the status register index (30) and the link register index (31).
- Natural sub-module: proc_alu (add/sub/and/or/sll/sra, signed less-than, not-equal, overflow).

Test Plan:
- Reset → address_imem = 0; wren = 0; ctrl_writeEnable = 0; after release, PC increments 0,1,2 on NOP stream.
- addi $1,$0,5 then add $2,$1,$1 → writes 5 to r1, then 10 to r2.
- add with $1 = 0x7FFFFFFF, $2 = 1 → writeReg = 30, data = 1. sub with 0x80000000 − 1 → r30 = 3.
- sw $1,4100($0) → address_dmem = 4100, wren = 1, data = $1. lw $3,4200($0) with q_dmem = 260 → r3 = 260.
- bne at PC 10 with imm = 3 and unequal operands → next PC 14; equal operands → PC 11. blt with −1 < 2 → branch taken.
- jal 20 at PC 5 → r31 = 6, PC = 20. jr $31 → PC = 6. setx 7 then bex 40 → PC = 40; with r30 = 0, bex falls through.
